// File: rtl/i2c_sht40_responder.sv
// i2c_sht40_responder: I2C target that emulates an SHT40 sensor at the bus level.
// It ACKs its address and accepts the measure (0xFD) and soft-reset (0x94) commands.
// After a measure it NACKs reads for MEAS_CYCLES clocks. It then returns
// T_msb, T_lsb, CRC, RH_msb, RH_lsb, CRC.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   scl_in, sda_in     asynchronous bus levels
//   sda_oe             1 = pull SDA low (open-drain)
//   temp_value         raw temperature word, latched on measure command
//   rh_value           raw humidity word, latched on measure command
//   cmd_valid          one-cycle pulse per accepted command byte
//   cmd_byte           last accepted command byte
//   meas_busy          measurement window active
//   data_ready         result latched and not yet read
//   bus_busy           between START and STOP
//   crc_inject         only with SHT40_CRC_INJECT_EN: flips bit 0 of both CRC bytes
// Optional macro: SHT40_CRC_INJECT_EN
module i2c_sht40_responder #(
   parameter logic [6:0]  ADDR        = 7'h44,
   parameter int unsigned MEAS_CYCLES = 1000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] temp_value,
   input  logic [15:0] rh_value,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        meas_busy,
   output logic        data_ready,
   output logic        bus_busy
`ifdef SHT40_CRC_INJECT_EN
   ,
   input  logic        crc_inject
`endif
);
   localparam int unsigned CNT_W    = $clog2(MEAS_CYCLES + 1);
   localparam logic [7:0]  CMD_MEAS = 8'hFD;
   localparam logic [7:0]  CMD_SRST = 8'h94;
   localparam logic [7:0]  CRC_POLY = 8'h31;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
   } state_t;

   state_t state, state_nxt;
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_s, sda_s, scl_d, sda_d;
   logic scl_rise_c, scl_fall_c, start_c, stop_c;
   logic [3:0] bit_cnt, bit_cnt_nxt;
   logic [6:0] shreg, shreg_nxt;
   logic [7:0] rx_byte_c;
   logic ack, ack_nxt, rw, rw_nxt;
   logic [2:0] byte_idx, byte_idx_nxt, tx_idx_c;
   logic [7:0] tx_sh, tx_sh_nxt, tx_byte_c;
   logic sda_oe_nxt;
   logic cmd_hit_c, meas_go_c, soft_rst_c, dr_clr_c;
   logic [15:0] temp_sh, rh_sh;
   logic [7:0]  crc_t, crc_h, crc_flip_c;
   logic [4:0]  crc_cnt;
   logic [CNT_W-1:0] meas_cnt;

   // Input synchronizers plus one history flop; idle bus level is high
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s      = scl_sync[SYNC_STAGES-1];
   assign sda_s      = sda_sync[SYNC_STAGES-1];
   assign scl_rise_c = scl_s & ~scl_d;
   assign scl_fall_c = ~scl_s & scl_d;
   assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;
   assign rx_byte_c  = {shreg, sda_s};

   // Byte to load at the next byte boundary: index 0 from ADDR_ACK, index+1 from TX_ACK
   assign tx_idx_c = (state == S_TX_ACK) ? byte_idx + 3'd1 : 3'd0;
   always_comb begin
      case (tx_idx_c)
         3'd0:    tx_byte_c = temp_sh[15:8];
         3'd1:    tx_byte_c = temp_sh[7:0];
         3'd2:    tx_byte_c = crc_t ^ crc_flip_c;
         3'd3:    tx_byte_c = rh_sh[15:8];
         3'd4:    tx_byte_c = rh_sh[7:0];
         default: tx_byte_c = crc_h ^ crc_flip_c;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         ack      <= 1'b0;
         rw       <= 1'b0;
         byte_idx <= '0;
         tx_sh    <= '0;
         sda_oe   <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shreg    <= shreg_nxt;
         ack      <= ack_nxt;
         rw       <= rw_nxt;
         byte_idx <= byte_idx_nxt;
         tx_sh    <= tx_sh_nxt;
         sda_oe   <= sda_oe_nxt;
      end
   end

   // FSM next state; bus conditions override SCL edge handling
   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      shreg_nxt    = shreg;
      ack_nxt      = ack;
      rw_nxt       = rw;
      byte_idx_nxt = byte_idx;
      tx_sh_nxt    = tx_sh;
      sda_oe_nxt   = sda_oe;
      cmd_hit_c    = 1'b0;
      meas_go_c    = 1'b0;
      soft_rst_c   = 1'b0;
      dr_clr_c     = 1'b0;
      if (start_c) begin
         state_nxt   = S_ADDR;
         bit_cnt_nxt = '0;
         sda_oe_nxt  = 1'b0;
      end else if (stop_c) begin
         state_nxt  = S_IDLE;
         sda_oe_nxt = 1'b0;
      end else begin
         case (state)
            S_ADDR, S_CMD: begin
               if (scl_rise_c && bit_cnt < 4'd8) begin
                  shreg_nxt   = rx_byte_c[6:0];
                  bit_cnt_nxt = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     if (state == S_ADDR) begin
                        rw_nxt  = rx_byte_c[0];
                        ack_nxt = ~rx_byte_c[0] | (~meas_busy & data_ready);
                        if (rx_byte_c[7:1] != ADDR) state_nxt = S_WAIT_STOP;
                     end else begin
                        meas_go_c  = (rx_byte_c == CMD_MEAS);
                        soft_rst_c = (rx_byte_c == CMD_SRST);
                        cmd_hit_c  = meas_go_c | soft_rst_c;
                        ack_nxt    = cmd_hit_c;
                     end
                  end
               end else if (scl_fall_c && bit_cnt == 4'd8) begin
                  // ACK slot opens: drive low only for an accepted byte
                  state_nxt  = (state == S_ADDR) ? S_ADDR_ACK : S_CMD_ACK;
                  sda_oe_nxt = ack;
                  dr_clr_c   = (state == S_ADDR) & rw & ack;
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall_c) begin
                  if (!ack) begin
                     state_nxt  = S_WAIT_STOP;
                     sda_oe_nxt = 1'b0;
                  end else if (rw) begin
                     state_nxt    = S_TX;
                     byte_idx_nxt = 3'd0;
                     sda_oe_nxt   = ~tx_byte_c[7];
                     tx_sh_nxt    = {tx_byte_c[6:0], 1'b0};
                     bit_cnt_nxt  = 4'd1;
                  end else begin
                     state_nxt   = S_CMD;
                     bit_cnt_nxt = '0;
                     sda_oe_nxt  = 1'b0;
                  end
               end
            end
            S_CMD_ACK: begin
               if (scl_fall_c) begin
                  state_nxt  = S_WAIT_STOP;
                  sda_oe_nxt = 1'b0;
               end
            end
            S_TX: begin
               // bit_cnt counts bits already placed on the bus
               if (scl_fall_c) begin
                  if (bit_cnt < 4'd8) begin
                     sda_oe_nxt  = ~tx_sh[7];
                     tx_sh_nxt   = {tx_sh[6:0], 1'b0};
                     bit_cnt_nxt = bit_cnt + 4'd1;
                  end else begin
                     sda_oe_nxt = 1'b0;
                     state_nxt  = S_TX_ACK;
                  end
               end
            end
            S_TX_ACK: begin
               if (scl_rise_c) begin
                  ack_nxt = ~sda_s;
               end else if (scl_fall_c) begin
                  if (ack && byte_idx != 3'd5) begin
                     state_nxt    = S_TX;
                     byte_idx_nxt = tx_idx_c;
                     sda_oe_nxt   = ~tx_byte_c[7];
                     tx_sh_nxt    = {tx_byte_c[6:0], 1'b0};
                     bit_cnt_nxt  = 4'd1;
                  end else begin
                     state_nxt  = S_WAIT_STOP;
                     sda_oe_nxt = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bit-serial CRC-8; data words rotate 16 times so they end up unchanged for TX
   always_ff @(posedge clk) begin
      if (rst) begin
         temp_sh <= '0;
         rh_sh   <= '0;
         crc_t   <= '0;
         crc_h   <= '0;
         crc_cnt <= '0;
      end else if (meas_go_c) begin
         temp_sh <= temp_value;
         rh_sh   <= rh_value;
         crc_t   <= 8'hFF;
         crc_h   <= 8'hFF;
         crc_cnt <= 5'd16;
      end else if (crc_cnt != 5'd0) begin
         crc_t   <= {crc_t[6:0], 1'b0} ^ ((crc_t[7] ^ temp_sh[15]) ? CRC_POLY : 8'h00);
         crc_h   <= {crc_h[6:0], 1'b0} ^ ((crc_h[7] ^ rh_sh[15]) ? CRC_POLY : 8'h00);
         temp_sh <= {temp_sh[14:0], temp_sh[15]};
         rh_sh   <= {rh_sh[14:0], rh_sh[15]};
         crc_cnt <= crc_cnt - 5'd1;
      end
   end

`ifdef SHT40_CRC_INJECT_EN
   logic inj_q;
   // Fault-injection select captured with the data
   always_ff @(posedge clk) begin
      if (rst)            inj_q <= 1'b0;
      else if (meas_go_c) inj_q <= crc_inject;
   end
   assign crc_flip_c = {7'b0, inj_q};
`else
   assign crc_flip_c = 8'h00;
`endif

   // Measurement window, command reporting and bus activity flags
   always_ff @(posedge clk) begin
      if (rst) begin
         meas_cnt   <= '0;
         meas_busy  <= 1'b0;
         data_ready <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_byte   <= 8'h00;
         bus_busy   <= 1'b0;
      end else begin
         cmd_valid <= cmd_hit_c;
         if (cmd_hit_c) cmd_byte <= rx_byte_c;
         if (start_c)     bus_busy <= 1'b1;
         else if (stop_c) bus_busy <= 1'b0;
         if (meas_go_c) begin
            meas_cnt   <= CNT_W'(MEAS_CYCLES);
            meas_busy  <= 1'b1;
            data_ready <= 1'b0;
         end else if (soft_rst_c) begin
            meas_cnt   <= '0;
            meas_busy  <= 1'b0;
            data_ready <= 1'b0;
         end else begin
            if (meas_cnt != '0) begin
               meas_cnt <= meas_cnt - CNT_W'(1);
               if (meas_cnt == CNT_W'(1)) begin
                  meas_busy  <= 1'b0;
                  data_ready <= 1'b1;
               end
            end
            if (dr_clr_c) data_ready <= 1'b0;
         end
      end
   end

endmodule
